pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the uRISC 5-stage core. It sits beside decode and owns all stall, bubble, flush and PC-redirect decisions. It tracks in-flight register writes in a small scoreboard to interlock RAW hazards. It also sequences HALT, illegal-op exception entry and return-from-exception through a small state machine, and holds the EPC.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_if.sv | 49 ++++
 rtl/pipe_ctrl_hazard_scoreboard.sv | 60 ++++++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the uRISC pipeline sequencing controller.
// Imported by the interface, the scoreboard and the top level.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    EXC        = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
  } sb_entry_t;

  localparam logic [15:0] EXC_VECTOR_DEFAULT = 16'h0002;
  localparam sb_entry_t   SB_EMPTY           = '{valid: 1'b0, dest: 3'd0};

  // True when a source that is actually read matches a pending write.
  function automatic logic src_hit(input logic used, input logic [2:0] src,
                                   input sb_entry_t e);
    return used && e.valid && (e.dest == src);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode-side and PC-side signal bundle of pipe_ctrl.
// The controller sits on the slave modport; decode/fetch/bench on master.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  // Handshake: the ID instruction is accepted (issues) in a cycle with
  // id_valid_p2=1 where the controller raises neither stall_id_p2 nor
  // bubble_ix_p3; while stall_id_p2=1 decode must hold the same instruction.
  logic        id_valid_p2;
  logic [15:0] pc_p2;
  logic [2:0]  rs_p2;
  logic [2:0]  rt_p2;
  logic        rs_used_p2;
  logic        rt_used_p2;
  logic [2:0]  dest_reg_p2;
  logic        reg_write_valid_p2;
  logic        halt_p2;
  logic        illegal_op_p2;
  logic        rti_p2;
  logic        redirect_ix_p3;
  logic [15:0] redirect_target_ix_p3;

  logic        stall_if_p1;
  logic        stall_id_p2;
  logic        bubble_ix_p3;
  logic        flush_ifid_p2;
  logic        pc_redirect_p1;
  logic [15:0] pc_target_p1;
  logic [15:0] epc_p1;
  logic        halted;
  ctrl_state_t state_dbg;

  modport master (
    output id_valid_p2, pc_p2, rs_p2, rt_p2, rs_used_p2, rt_used_p2,
           dest_reg_p2, reg_write_valid_p2, halt_p2, illegal_op_p2, rti_p2,
           redirect_ix_p3, redirect_target_ix_p3,
    input  stall_if_p1, stall_id_p2, bubble_ix_p3, flush_ifid_p2,
           pc_redirect_p1, pc_target_p1, epc_p1, halted, state_dbg
  );

  modport slave (
    input  id_valid_p2, pc_p2, rs_p2, rt_p2, rs_used_p2, rt_used_p2,
           dest_reg_p2, reg_write_valid_p2, halt_p2, illegal_op_p2, rti_p2,
           redirect_ix_p3, redirect_target_ix_p3,
    output stall_if_p1, stall_id_p2, bubble_ix_p3, flush_ifid_p2,
           pc_redirect_p1, pc_target_p1, epc_p1, halted, state_dbg
  );

endinterface

// File: rtl/pipe_ctrl_hazard_scoreboard.sv
// Three-entry in-flight write tracker (IX -> MEM -> WB) with RAW compare.
// Produces a single hazard bit plus occupancy summaries for the sequencer.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic       wr_valid,
  input  logic [2:0] wr_dest,
  input  logic       check,
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  input  logic       rs_used,
  input  logic       rt_used,
  output logic       hazard,
  output logic       ix_mem_busy,
  output logic       any_busy
);

  sb_entry_t ix_q, mem_q, wb_q;
  sb_entry_t ix_d, mem_d, wb_d;
  logic      hit_ix, hit_mem, hit_wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ix_q  <= SB_EMPTY;
      mem_q <= SB_EMPTY;
      wb_q  <= SB_EMPTY;
    end else begin
      ix_q  <= ix_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_comb begin
    ix_d  = SB_EMPTY;
    if (issue) begin
      ix_d.valid = wr_valid;
      ix_d.dest  = wr_dest;
    end
    mem_d = ix_q;
    wb_d  = mem_q;
  end

  // A write-before-read register file resolves the WB-stage producer itself.
  always_comb begin
    hit_ix  = src_hit(rs_used, rs, ix_q)  || src_hit(rt_used, rt, ix_q);
    hit_mem = src_hit(rs_used, rs, mem_q) || src_hit(rt_used, rt, mem_q);
    hit_wb  = src_hit(rs_used, rs, wb_q)  || src_hit(rt_used, rt, wb_q);
    hazard  = check && (hit_ix || hit_mem || (!WB_BYPASS && hit_wb));
  end

  assign ix_mem_busy = ix_q.valid || mem_q.valid;
  assign any_busy    = ix_q.valid || mem_q.valid || wb_q.valid;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall/bubble/flush/redirect decisions,
// RAW interlock, and the HALT / exception / RTI sequencer holding the EPC.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter bit          WB_BYPASS  = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  pipe_ctrl_if.slave bus
);

  ctrl_state_t state_q, state_d;
  logic [15:0] epc_q, epc_d;

  logic        hazard, ix_mem_busy, any_busy, issue;
  logic        stall_if, stall_id, bubble, flush, pc_redirect;
  logic [15:0] pc_target;

  hazard_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue),
    .wr_valid    (bus.reg_write_valid_p2),
    .wr_dest     (bus.dest_reg_p2),
    .check       (bus.id_valid_p2),
    .rs          (bus.rs_p2),
    .rt          (bus.rt_p2),
    .rs_used     (bus.rs_used_p2),
    .rt_used     (bus.rt_used_p2),
    .hazard      (hazard),
    .ix_mem_busy (ix_mem_busy),
    .any_busy    (any_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      epc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  // Only an ID instruction that survives redirect and hazard checks acts.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    case (state_q)
      RUN: begin
        if (!bus.redirect_ix_p3 && bus.id_valid_p2 && !hazard) begin
          if (bus.illegal_op_p2) begin
            epc_d   = bus.pc_p2 + 16'd2;
            state_d = EXC;
          end else if (bus.halt_p2) begin
            state_d = HALT_DRAIN;
          end
        end
      end
      EXC:        if (!ix_mem_busy) state_d = RUN;
      HALT_DRAIN: if (!any_busy)    state_d = HALTED;
      HALTED:     state_d = HALTED;
      default:    state_d = RUN;
    endcase
  end

  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 16'h0000;
    issue       = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.redirect_ix_p3) begin
          pc_redirect = 1'b1;
          pc_target   = bus.redirect_target_ix_p3;
          flush       = 1'b1;
          bubble      = 1'b1;
        end else if (bus.id_valid_p2 && hazard) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          bubble   = 1'b1;
        end else if (bus.id_valid_p2) begin
          if (bus.illegal_op_p2) begin
            bubble = 1'b1;
            flush  = 1'b1;
          end else if (bus.rti_p2) begin
            pc_redirect = 1'b1;
            pc_target   = epc_q;
            bubble      = 1'b1;
            flush       = 1'b1;
          end else if (bus.halt_p2) begin
            bubble = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
      end
      // Fetch is frozen until the older writers have left IX and MEM.
      EXC: begin
        stall_if = 1'b1;
        if (!ix_mem_busy) begin
          pc_redirect = 1'b1;
          pc_target   = EXC_VECTOR;
          flush       = 1'b1;
        end
      end
      HALT_DRAIN, HALTED: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        bubble   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.stall_if_p1    = stall_if;
  assign bus.stall_id_p2    = stall_id;
  assign bus.bubble_ix_p3   = bubble;
  assign bus.flush_ifid_p2  = flush;
  assign bus.pc_redirect_p1 = pc_redirect;
  assign bus.pc_target_p1   = pc_target;
  assign bus.epc_p1         = epc_q;
  assign bus.halted         = (state_q == HALTED);
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (WB bypass on/off) share one stimulus
// stream and are each checked against a timestamp-based reference model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [15:0] VEC = 16'h0002;

  typedef struct packed {
    logic        id_valid;
    logic [15:0] pc;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        rs_used;
    logic        rt_used;
    logic [2:0]  dest;
    logic        rwv;
    logic        halt;
    logic        illegal;
    logic        rti;
    logic        redir;
    logic [15:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [1:0]  st;
    logic        sif;
    logic        sid;
    logic        bub;
    logic        flush;
    logic        pcr;
    logic [15:0] tgt;
    logic [15:0] epc;
    logic        halted;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stim_t cur;
  pipe_ctrl_if bus1 ();
  pipe_ctrl_if bus0 ();

  pipe_ctrl #(.EXC_VECTOR(VEC), .WB_BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipe_ctrl #(.EXC_VECTOR(VEC), .WB_BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus1.id_valid_p2 = cur.id_valid;            assign bus0.id_valid_p2 = cur.id_valid;
  assign bus1.pc_p2 = cur.pc;                        assign bus0.pc_p2 = cur.pc;
  assign bus1.rs_p2 = cur.rs;                        assign bus0.rs_p2 = cur.rs;
  assign bus1.rt_p2 = cur.rt;                        assign bus0.rt_p2 = cur.rt;
  assign bus1.rs_used_p2 = cur.rs_used;              assign bus0.rs_used_p2 = cur.rs_used;
  assign bus1.rt_used_p2 = cur.rt_used;              assign bus0.rt_used_p2 = cur.rt_used;
  assign bus1.dest_reg_p2 = cur.dest;                assign bus0.dest_reg_p2 = cur.dest;
  assign bus1.reg_write_valid_p2 = cur.rwv;          assign bus0.reg_write_valid_p2 = cur.rwv;
  assign bus1.halt_p2 = cur.halt;                    assign bus0.halt_p2 = cur.halt;
  assign bus1.illegal_op_p2 = cur.illegal;           assign bus0.illegal_op_p2 = cur.illegal;
  assign bus1.rti_p2 = cur.rti;                      assign bus0.rti_p2 = cur.rti;
  assign bus1.redirect_ix_p3 = cur.redir;            assign bus0.redirect_ix_p3 = cur.redir;
  assign bus1.redirect_target_ix_p3 = cur.tgt;       assign bus0.redirect_target_ix_p3 = cur.tgt;

  exp_t obs1, obs0;
  assign obs1 = {bus1.state_dbg, bus1.stall_if_p1, bus1.stall_id_p2, bus1.bubble_ix_p3,
                 bus1.flush_ifid_p2, bus1.pc_redirect_p1, bus1.pc_target_p1, bus1.epc_p1,
                 bus1.halted};
  assign obs0 = {bus0.state_dbg, bus0.stall_if_p1, bus0.stall_id_p2, bus0.bubble_ix_p3,
                 bus0.flush_ifid_p2, bus0.pc_redirect_p1, bus0.pc_target_p1, bus0.epc_p1,
                 bus0.halted};

  // ---------------- reference model ----------------
  // mode: 0 run, 1 exception drain, 2 halt drain, 3 halted.
  // A write issued at cycle c occupies IX/MEM/WB during c+1..c+3.
  int          t;
  int          m_mode[2];
  logic [15:0] m_epc[2];
  int          m_last_w[2][8];
  int          m_last_any[2];

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_mode[b]     = 0;
      m_epc[b]      = 16'h0000;
      m_last_any[b] = -100;
      for (int r = 0; r < 8; r++) m_last_w[b][r] = -100;
    end
  endtask

  task automatic model_step(input int b, input stim_t s, output exp_t e);
    int   win;
    logic hz;
    win      = (b == 1) ? 2 : 3;
    e        = '0;
    e.st     = 2'(m_mode[b]);
    e.epc    = m_epc[b];
    e.halted = (m_mode[b] == 3);
    case (m_mode[b])
      0: begin
        if (s.redir) begin
          e.pcr = 1'b1; e.tgt = s.tgt; e.flush = 1'b1; e.bub = 1'b1;
        end else if (s.id_valid) begin
          hz = (s.rs_used && (t - m_last_w[b][s.rs] <= win)) ||
               (s.rt_used && (t - m_last_w[b][s.rt] <= win));
          if (hz) begin
            e.sif = 1'b1; e.sid = 1'b1; e.bub = 1'b1;
          end else if (s.illegal) begin
            e.bub = 1'b1; e.flush = 1'b1;
            m_epc[b]  = s.pc + 16'd2;
            m_mode[b] = 1;
          end else if (s.rti) begin
            e.pcr = 1'b1; e.tgt = m_epc[b]; e.bub = 1'b1; e.flush = 1'b1;
          end else if (s.halt) begin
            e.bub = 1'b1;
            m_mode[b] = 2;
          end else if (s.rwv) begin
            m_last_w[b][s.dest] = t;
            m_last_any[b]       = t;
          end
        end
      end
      1: begin
        e.sif = 1'b1;
        if (t - m_last_any[b] > 2) begin
          e.pcr = 1'b1; e.tgt = VEC; e.flush = 1'b1;
          m_mode[b] = 0;
        end
      end
      2: begin
        e.sif = 1'b1; e.sid = 1'b1; e.bub = 1'b1;
        if (t - m_last_any[b] > 3) m_mode[b] = 3;
      end
      default: begin
        e.sif = 1'b1; e.sid = 1'b1; e.bub = 1'b1;
      end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_models();
    exp_t e1, e0;
    model_step(1, cur, e1);
    model_step(0, cur, e0);
    exp_q.push_back(e1);
    exp_q.push_back(e0);
    chk($sformatf("byp1_t%0d", t), obs1, exp_q.pop_front());
    chk($sformatf("byp0_t%0d", t), obs0, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input stim_t s);
    cur = s;
    #1;
  endtask

  task automatic tick();
    t++;
    @(negedge clk);
  endtask

  task automatic step(input stim_t s);
    apply(s);
    check_models();
    tick();
  endtask

  function automatic stim_t mk(input logic [15:0] pc, input logic [2:0] rs, input logic ru,
                               input logic [2:0] rt, input logic tu,
                               input logic [2:0] d, input logic w, input int cls);
    stim_t s;
    s          = '0;
    s.id_valid = 1'b1;
    s.pc       = pc;
    s.rs       = rs; s.rs_used = ru;
    s.rt       = rt; s.rt_used = tu;
    s.dest     = d;  s.rwv     = w;
    s.halt     = (cls == 1);
    s.illegal  = (cls == 2);
    s.rti      = (cls == 3);
    return s;
  endfunction

  function automatic stim_t rnd_stim(input logic allow_redir);
    stim_t s;
    int    k;
    k = int'($urandom_range(0, 99));
    s = mk(16'($urandom_range(0, 32767) * 2), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), (k < 2) ? 2 : (k < 4) ? 3 : (k < 5) ? 1 : 0);
    s.id_valid = ($urandom_range(0, 9) < 7);
    s.redir    = allow_redir && ($urandom_range(0, 99) < 8);
    s.tgt      = 16'($urandom_range(0, 65535));
    return s;
  endfunction

  stim_t idle;
  assign idle = '0;

  // ---------------- directed + random sequence ----------------
  initial begin
    stim_t s;
    int    halt_cnt;
    rst = 1'b1;
    cur = '0;
    t   = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    apply(idle);
    chk("reset_target", bus1.pc_target_p1, 16'h0000);
    chk("reset_stall", {bus1.stall_if_p1, bus0.stall_id_p2, bus1.bubble_ix_p3}, 0);
    check_models();
    tick();

    // ALU writes R3, consumer reads R3: 2 stalls with bypass, 3 without
    step(mk(16'h0100, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 0));
    s = mk(16'h0102, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      apply(s);
      chk($sformatf("lu_byp1_stall%0d", i), bus1.stall_id_p2, (i < 2) ? 1 : 0);
      chk($sformatf("lu_byp0_stall%0d", i), bus0.stall_id_p2, (i < 3) ? 1 : 0);
      check_models();
      tick();
    end
    repeat (4) step(idle);

    // redirect wins over a pending hazard
    step(mk(16'h0200, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 0));
    s = mk(16'h0202, 3'd5, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 0);
    s.redir = 1'b1;
    s.tgt   = 16'h0040;
    apply(s);
    chk("redir_pcr", bus1.pc_redirect_p1, 1);
    chk("redir_tgt", bus1.pc_target_p1, 16'h0040);
    chk("redir_flush", bus0.flush_ifid_p2, 1);
    chk("redir_nostall", {bus1.stall_id_p2, bus0.stall_id_p2}, 0);
    check_models();
    tick();
    repeat (4) step(idle);

    // illegal op with IX and MEM occupied, then RTI
    step(mk(16'h000C, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 0));
    step(mk(16'h000E, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 0));
    step(mk(16'h0010, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2));
    apply(idle);
    chk("exc_epc", bus1.epc_p1, 16'h0012);
    chk("exc_wait", bus1.pc_redirect_p1, 0);
    check_models();
    tick();
    apply(idle);
    chk("exc_vec_pcr", bus1.pc_redirect_p1, 1);
    chk("exc_vec_tgt", bus0.pc_target_p1, VEC);
    check_models();
    tick();
    apply(mk(16'h0002, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3));
    chk("exc_run", bus1.state_dbg, RUN);
    chk("rti_tgt", {bus1.pc_redirect_p1, bus1.pc_target_p1}, {1'b1, 16'h0012});
    check_models();
    tick();
    repeat (3) step(idle);

    // HALT with three writes in flight
    for (int i = 0; i < 3; i++)
      step(mk(16'h0300, 3'd0, 1'b0, 3'd0, 1'b0, 3'(i + 5), 1'b1, 0));
    step(mk(16'h0306, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1));
    for (int i = 0; i < 3; i++) begin
      apply(idle);
      chk($sformatf("drain%0d", i), {bus1.state_dbg, bus1.halted}, {HALT_DRAIN, 1'b0});
      check_models();
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      apply(rnd_stim(1'b0));
      cur.id_valid = i[0];
      #1;
      chk($sformatf("halted%0d", i), {bus1.halted, bus0.halted}, 2'b11);
      check_models();
      tick();
    end

    // EPC wrap, then asynchronous reset in the middle of a halt drain
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(mk(16'hFFFE, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2));
    apply(idle);
    chk("wrap_epc", bus0.epc_p1, 16'h0000);
    check_models();
    tick();
    step(mk(16'h0100, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2));
    step(idle);
    step(mk(16'h0104, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 0));
    step(mk(16'h0106, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 0));
    step(mk(16'h0108, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1));
    cur = idle;
    #1;
    chk("pre_rst_drain", {bus1.stall_id_p2, bus1.epc_p1}, {1'b1, 16'h0102});
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {bus1.halted, bus1.epc_p1, bus1.stall_if_p1, bus1.stall_id_p2,
                      bus1.bubble_ix_p3, bus1.state_dbg}, 0);
    chk("rst_async0", {bus0.stall_if_p1, bus0.epc_p1}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(mk(16'h0400, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 0));
    chk("post_rst_issue", {bus1.stall_id_p2, bus1.bubble_ix_p3}, 0);
    check_models();
    tick();

    // randomized phase
    halt_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (halt_cnt > 5) begin
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        halt_cnt = 0;
      end
      step(rnd_stim(m_mode[0] == 0 && m_mode[1] == 0));
      if (m_mode[0] == 3 || m_mode[1] == 3) halt_cnt++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
